uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one tx_uart byte transmitter between two word-wide requesters (debug-unit dump, MIPS status).
//  Grants one requester round-robin, latches its word, feeds it to tx_uart LSB byte first, and reports completion.
//  Sits between the debug/control logic and tx_uart.
// PARAMETERS
//  N_DATA       8   byte width of the tx_uart data port
//  N_WORD       32  requester word width; must be a multiple of N_DATA (N_BYTES = N_WORD/N_DATA)
//  ACK_TIMEOUT  16  cycles to wait for read_tx after tx_start before aborting
// PORTS
//  clock         in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  req           in   2       level request per requester; held with word until ack
//  word_0        in   N_WORD  payload of requester 0
//  word_1        in   N_WORD  payload of requester 1
//  ack           out  2       1-cycle pulse: word latched, requester may change word/req
//  done          out  2       1-cycle pulse: last byte's stop bit finished
//  err           out  1       1-cycle pulse: tx_uart did not accept within ACK_TIMEOUT
//  busy          out  1       high from grant until done/err
//  tx_din        out  N_DATA  byte to tx_uart din
//  tx_start      out  1       start request to tx_uart
//  read_tx       in   1       tx_uart accept pulse
//  tx_done_tick  in   1       tx_uart done; high continuously in its idle, pulses at stop end
// BEHAVIOUR
//  - All outputs registered. Reset: ack=0, done=0, err=0, busy=0, tx_start=0, tx_din=0, state=IDLE,
//    byte_idx=0, last_grant=1 (requester 0 wins first). Reset mid-transfer aborts silently: no done, no err.
//  - FSM states: IDLE, SEND, SETTLE, WAIT_DONE.
//  - IDLE: if any req, pick g (only one -> it; both -> requester != last_grant). That edge: word_reg<=word_g,
//    ack[g]<=1, busy<=1, byte_idx<=0, tx_start<=1, tx_din<=word_g[7:0], -> SEND.
//  - SEND: hold tx_start and tx_din stable. On read_tx=1: tx_start<=0 -> SETTLE.
//    Timeout counter counts cycles in SEND; at ACK_TIMEOUT-1 without read_tx: tx_start<=0, err<=1,
//    busy<=0, last_grant<=g -> IDLE.
//  - SETTLE: exactly one cycle; tx_done_tick ignored (still high from tx_uart idle) -> WAIT_DONE.
//  - WAIT_DONE: wait for tx_done_tick=1. If byte_idx==N_BYTES-1: done[g]<=1, busy<=0, last_grant<=g -> IDLE.
//    Else byte_idx+1, tx_din<=word_reg[(byte_idx+1)*N_DATA +: N_DATA], tx_start<=1 -> SEND.
//  - Requests are ignored outside IDLE; a req held through a transfer is serviced after it. No req queue.
//  - Same requester may re-request the cycle after its done; if the other is also requesting, the other wins.
//  - byte_idx width = clog2(N_BYTES); it never wraps past N_BYTES-1.
//  - Per-byte latency: IDLE->first tx_start visible 1 cycle after req sampled;
//    next byte's tx_start visible 1 cycle after tx_done_tick.
// STRUCTURE
//  - Shared package/header: FSM state localparams (one-hot, 4 bits), N_BYTES derivation, requester index constants.
//  - Round-robin pick is a 2-input function inside the module; no sub-module required.
//  - Single always @(posedge clock) for registers plus one always @(*) next-state block.
// TESTING
//  (Bench uses real tx_uart with a tick generator, or a model holding tx_done_tick=1 when idle.)
//  1. req=2'b01, word_0=32'h11223344 -> tx_din sequence 8'h44,8'h33,8'h22,8'h11; one ack[0];
//     one done[0] after 4th tx_done_tick; serial line decodes same bytes.
//  2. Both req high after reset, word_0=32'hA5A5A5A5, word_1=32'h0F0F0F0F -> requester 0 served
//     fully first, then 1; ack/done order 0,1.
//  3. req held high on both for 4 transfers -> grants alternate 0,1,0,1; busy low exactly 1+ cycles between.
//  4. Model holds read_tx=0 -> err pulse exactly ACK_TIMEOUT cycles after tx_start rose; no done; returns IDLE.
//  5. Reset asserted during byte 2 of word_1 -> next cycle all outputs at reset values;
//     a following req=2'b10 restarts at byte 0.
//  6. Idle-level tx_done_tick=1 in SETTLE -> byte_idx must not advance; only later done pulse advances it.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int REQ_0 = 0;
  localparam int REQ_1 = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_SEND      = 4'b0010,
    ST_SETTLE    = 4'b0100,
    ST_WAIT_DONE = 4'b1000
  } state_t;

  function automatic int calcNBytes(input int nWord, input int nData);
    return nWord / nData;
  endfunction

  // A single-byte word still needs a one-bit index register.
  function automatic int idxWidth(input int nBytes);
    return (nBytes > 1) ? $clog2(nBytes) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_timer.sv
// Accept-timeout counter: runs while the arbiter waits for tx_uart to take a byte.
module uart_tx_arbiter_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Cleared whenever the arbiter is outside SEND, so every byte gets a fresh window.
  always_ff @(posedge clock) begin
    if (reset || !i_run) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one tx_uart from two word-wide requesters, LSB byte first.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_DATA      = 8,
  parameter int N_WORD      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [N_WORD-1:0] word_0,
  input  logic [N_WORD-1:0] word_1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic              err,
  output logic              busy,
  output logic [N_DATA-1:0] tx_din,
  output logic              tx_start,
  input  logic              read_tx,
  input  logic              tx_done_tick
);

  localparam int N_BYTES = calcNBytes(N_WORD, N_DATA);
  localparam int IDXW    = idxWidth(N_BYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_BYTES - 1);

  state_t            r_state, w_state;
  logic [IDXW-1:0]   r_byteIdx, w_byteIdx;
  logic              r_lastGrant, w_lastGrant;
  logic              r_grant, w_grant;
  logic [N_WORD-1:0] r_wordReg, w_wordReg;
  logic [N_DATA-1:0] r_txDin, w_txDin;
  logic              r_txStart, w_txStart;
  logic              r_err, w_err;
  logic              r_busy, w_busy;
  logic [1:0]        r_ack, w_ack;
  logic [1:0]        r_done, w_done;

  logic              w_pick;
  logic [N_WORD-1:0] w_pickWord;
  logic [IDXW-1:0]   w_nextIdx;
  logic              w_timeout;

  // Lone requester wins outright; on contention the one not served last wins.
  function automatic logic pickRequester(input logic [1:0] reqs, input logic lastGrant);
    if (reqs == 2'b01) return 1'(REQ_0);
    if (reqs == 2'b10) return 1'(REQ_1);
    return ~lastGrant;
  endfunction

  uart_tx_arbiter_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_run    (r_state == ST_SEND),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_byteIdx   <= '0;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_wordReg   <= '0;
      r_txDin     <= '0;
      r_txStart   <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= '0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state;
      r_byteIdx   <= w_byteIdx;
      r_lastGrant <= w_lastGrant;
      r_grant     <= w_grant;
      r_wordReg   <= w_wordReg;
      r_txDin     <= w_txDin;
      r_txStart   <= w_txStart;
      r_err       <= w_err;
      r_busy      <= w_busy;
      r_ack       <= w_ack;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_byteIdx   = r_byteIdx;
    w_lastGrant = r_lastGrant;
    w_grant     = r_grant;
    w_wordReg   = r_wordReg;
    w_txDin     = r_txDin;
    w_txStart   = r_txStart;
    w_busy      = r_busy;
    w_err       = 1'b0;
    w_ack       = '0;
    w_done      = '0;
    w_pick      = pickRequester(req, r_lastGrant);
    w_pickWord  = w_pick ? word_1 : word_0;
    w_nextIdx   = r_byteIdx + 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_grant        = w_pick;
          w_wordReg      = w_pickWord;
          w_ack[w_pick]  = 1'b1;
          w_busy         = 1'b1;
          w_byteIdx      = '0;
          w_txStart      = 1'b1;
          w_txDin        = w_pickWord[N_DATA-1:0];
          w_state        = ST_SEND;
        end
      end
      ST_SEND: begin
        if (read_tx) begin
          w_txStart = 1'b0;
          w_state   = ST_SETTLE;
        end else if (w_timeout) begin
          w_txStart   = 1'b0;
          w_err       = 1'b1;
          w_busy      = 1'b0;
          w_lastGrant = r_grant;
          w_state     = ST_IDLE;
        end
      end
      // tx_done_tick is still at its idle-high level here, so it must not be trusted yet.
      ST_SETTLE: begin
        w_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done_tick) begin
          if (r_byteIdx == LAST_IDX) begin
            w_done[r_grant] = 1'b1;
            w_busy          = 1'b0;
            w_lastGrant     = r_grant;
            w_state         = ST_IDLE;
          end else begin
            w_byteIdx = w_nextIdx;
            w_txDin   = r_wordReg[int'(w_nextIdx) * N_DATA +: N_DATA];
            w_txStart = 1'b1;
            w_state   = ST_SEND;
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = r_busy;
  assign tx_din   = r_txDin;
  assign tx_start = r_txStart;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural tx_uart and transaction-level reference.
module tb_uart_tx_arbiter;

  localparam int N_DATA      = 8;
  localparam int N_WORD      = 32;
  localparam int ACK_TIMEOUT = 16;
  localparam int N_BYTES     = N_WORD / N_DATA;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req = 2'b00;
  logic [N_WORD-1:0] word_0 = '0;
  logic [N_WORD-1:0] word_1 = '0;
  logic [1:0]        ack;
  logic [1:0]        done;
  logic              err;
  logic              busy;
  logic [N_DATA-1:0] tx_din;
  logic              tx_start;
  logic              read_tx;
  logic              tx_done_tick;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lastRiseCyc = -100;
  int lastDoneCyc = -100;
  int stopEnds = 0;
  int stopEndsAtAck = 0;
  int errCount = 0;
  int lastServed = 1;
  int modelState = 0;
  int modelWait = 0;
  bit modelNoAccept = 1'b0;
  logic prevTxStart = 1'b0;
  logic [N_DATA-1:0] byteLog[$];
  int ackLog[$];
  int doneLog[$];

  uart_tx_arbiter #(
    .N_DATA(N_DATA),
    .N_WORD(N_WORD),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .word_0      (word_0),
    .word_1      (word_1),
    .ack         (ack),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .tx_din      (tx_din),
    .tx_start    (tx_start),
    .read_tx     (read_tx),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // tx_uart stand-in: idle-high done tick, accepts after a random delay, keeps the tick
  // high one extra cycle after accepting, then goes busy for a random time.
  initial begin
    read_tx = 1'b0;
    tx_done_tick = 1'b1;
    forever begin
      @(negedge clock);
      read_tx = 1'b0;
      if (reset) begin
        modelState = 0;
        tx_done_tick = 1'b1;
      end else begin
        case (modelState)
          0: if (tx_start && !modelNoAccept) begin
               if (modelWait > 0) modelWait--;
               else begin
                 read_tx = 1'b1;
                 byteLog.push_back(tx_din);
                 modelState = 1;
               end
             end
          1: modelState = 2;
          2: begin
               tx_done_tick = 1'b0;
               modelWait = $urandom_range(2, 6);
               modelState = 3;
             end
          default: if (modelWait > 0) modelWait--;
             else begin
               tx_done_tick = 1'b1;
               stopEnds++;
               lastRiseCyc = cyc;
               modelWait = $urandom_range(0, 3);
               modelState = 0;
             end
        endcase
      end
    end
  end

  // Event monitor sampling just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (!reset) begin
        if (ack[0]) ackLog.push_back(0);
        if (ack[1]) ackLog.push_back(1);
        if (|ack) stopEndsAtAck = stopEnds;
        if (|done) begin
          if (done[0]) doneLog.push_back(0);
          if (done[1]) doneLog.push_back(1);
          lastDoneCyc = cyc;
          checkOutput("doneLatency", cyc - lastRiseCyc, 1);
          checkOutput("stopsPerWord", stopEnds - stopEndsAtAck, N_BYTES);
        end
        if (err) errCount++;
        if (tx_start && !prevTxStart && ack == 2'b00)
          checkOutput("nextByteLatency", cyc - lastRiseCyc, 1);
      end
      prevTxStart = tx_start;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    byteLog.delete();
    ackLog.delete();
    doneLog.delete();
    errCount = 0;
    lastServed = 1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"}, ack, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_txStart"}, tx_start, 0);
    checkOutput({tag, "_txDin"}, tx_din, 0);
  endtask

  // Drives a request pattern and predicts grants/bytes from the round-robin rule.
  task automatic applyStimulus(input logic [1:0] startReq, input int nHold, input bit hold,
                               input string tag);
    int n;
    int acks = 0;
    int guard = 0;
    int gExp;
    int reqCyc;
    int expDone[$];
    logic [N_DATA-1:0] expBytes[$];
    logic [N_WORD-1:0] w;
    byteLog.delete();
    ackLog.delete();
    doneLog.delete();
    n = hold ? nHold : $countones(startReq);
    @(negedge clock);
    req = startReq;
    reqCyc = cyc;
    while (acks < n && guard < 3000) begin
      @(negedge clock);
      guard++;
      if (ack != 2'b00) begin
        gExp = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : ((lastServed == 0) ? 1 : 0);
        checkOutput({tag, "_grant"}, ack, longint'(1) << gExp);
        if (acks == 0) checkOutput({tag, "_grantLatency"}, cyc - reqCyc, 1);
        else checkOutput({tag, "_busyGap"}, cyc - lastDoneCyc, 1);
        w = (gExp == 0) ? word_0 : word_1;
        for (int i = 0; i < N_BYTES; i++)
          expBytes.push_back(N_DATA'((w >> (N_DATA * i)) & 32'hFF));
        expDone.push_back(gExp);
        lastServed = gExp;
        acks++;
        if (!hold) req[gExp] = 1'b0;
        if (acks == n) req = 2'b00;
        if (gExp == 0) word_0 = $urandom;
        else word_1 = $urandom;
      end
    end
    guard = 0;
    while (doneLog.size() < n && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    checkOutput({tag, "_doneCount"}, doneLog.size(), n);
    checkOutput({tag, "_byteCount"}, byteLog.size(), expBytes.size());
    foreach (expBytes[i])
      if (i < byteLog.size()) checkOutput({tag, "_byte"}, byteLog[i], expBytes[i]);
    foreach (expDone[i]) begin
      if (i < doneLog.size()) checkOutput({tag, "_doneOrder"}, doneLog[i], expDone[i]);
      if (i < ackLog.size()) checkOutput({tag, "_ackOrder"}, ackLog[i], expDone[i]);
    end
    checkOutput({tag, "_idleBusy"}, busy, 0);
  endtask

  initial begin
    int guard;
    int startCyc;
    logic [1:0] rr;

    doReset();
    checkResetState("reset");

    word_0 = 32'h11223344;
    applyStimulus(2'b01, 0, 1'b0, "single");

    doReset();
    word_0 = 32'hA5A5A5A5;
    word_1 = 32'h0F0F0F0F;
    applyStimulus(2'b11, 0, 1'b0, "bothReq");

    doReset();
    word_0 = $urandom;
    word_1 = $urandom;
    applyStimulus(2'b11, 4, 1'b1, "alternate");

    // Accept timeout.
    doReset();
    modelNoAccept = 1'b1;
    word_1 = $urandom;
    @(negedge clock);
    req = 2'b10;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (ack == 2'b00 && guard < 50);
    startCyc = cyc;
    checkOutput("timeoutAck", ack, 2'b10);
    checkOutput("timeoutTxStartHigh", tx_start, 1);
    req = 2'b00;
    guard = 0;
    while (!err && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("timeoutErr", err, 1);
    checkOutput("timeoutCycles", cyc - startCyc, ACK_TIMEOUT);
    checkOutput("timeoutBusy", busy, 0);
    checkOutput("timeoutTxStart", tx_start, 0);
    checkOutput("timeoutNoDone", doneLog.size(), 0);
    @(negedge clock);
    checkOutput("errPulseWidth", err, 0);
    modelNoAccept = 1'b0;
    lastServed = 1;
    word_0 = $urandom;
    applyStimulus(2'b01, 0, 1'b0, "afterErr");

    // Reset in the middle of a word from requester 1.
    doReset();
    word_1 = $urandom;
    @(negedge clock);
    req = 2'b10;
    guard = 0;
    while (byteLog.size() < 2 && guard < 500) begin
      @(negedge clock);
      guard++;
      if (ack != 2'b00) req = 2'b00;
    end
    checkOutput("midBytesSent", byteLog.size(), 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkResetState("midReset");
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midResetNoErr", errCount, 0);
    lastServed = 1;
    word_1 = $urandom;
    applyStimulus(2'b10, 0, 1'b0, "afterReset");

    // Randomized traffic without intervening resets.
    for (int k = 0; k < 6; k++) begin
      rr = 2'($urandom_range(1, 3));
      word_0 = $urandom;
      word_1 = $urandom;
      applyStimulus(rr, $urandom_range(1, 3), 1'($urandom_range(0, 1)), "rand");
    end
    checkOutput("randNoErr", errCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
